// File: rtl/booth_mul_arbiter.sv
// ============================================================================
// Module      : booth_mul_arbiter
// Description : Round-robin arbiter sharing one external combinational
//               signed 8x8 multiplier between NUM_REQ requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mul_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int MUL_CYCLES = 1,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_a,
    input  logic [8*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             mul_a,
    output logic [7:0]             mul_b,
    input  logic [15:0]            mul_product,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [15:0]            rsp_product,
    input  logic                   rsp_ready
);

    localparam logic [3:0] c_CNT_INIT = 4'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_gnt_id;
    logic [7:0]        r_op_a;
    logic [7:0]        r_op_b;
    logic [3:0]        r_cnt;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [15:0]       r_rsp_product;
    logic              w_any;
    logic [ID_W-1:0]   w_grant;

    // Modular increment that stays correct for non-power-of-two NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[ID_W-1:0];
    endfunction

    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_any && req_valid[wrap_add(r_rr_ptr, k)]) begin
                w_any   = 1'b1;
                w_grant = wrap_add(r_rr_ptr, k);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt        = S_MUL;
                    // Gated so a request seen during reset is never acknowledged.
                    req_ready[w_grant] = rst_n;
                end
            end
            S_MUL: begin
                if (r_cnt == '0) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr      <= '0;
            r_gnt_id      <= '0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_cnt         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_op_a   <= req_a[{w_grant, 3'b000} +: 8];
                        r_op_b   <= req_b[{w_grant, 3'b000} +: 8];
                        r_gnt_id <= w_grant;
                        r_cnt    <= c_CNT_INIT;
                    end
                end
                S_MUL: begin
                    if (r_cnt == '0) begin
                        r_rsp_product <= mul_product;
                        r_rsp_id      <= r_gnt_id;
                        r_rsp_valid   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rr_ptr    <= wrap_add(r_gnt_id, 1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Operands come straight from registers so the multiplier input is stable
    // for the whole multicycle window.
    assign mul_a       = r_op_a;
    assign mul_b       = r_op_b;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_product = r_rsp_product;

endmodule

`default_nettype wire

// File: tb/tb_booth_mul_arbiter.sv
// ============================================================================
// Module      : tb_booth_mul_arbiter
// Description : Scoreboard bench for booth_mul_arbiter (MUL_CYCLES 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_mul_arbiter;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] p;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    logic [3:0]  v0, v1, rr0, rr1, acc0, acc1;
    logic [31:0] a0, b0, a1, b1;
    logic [7:0]  mul_a0, mul_b0, mul_a1, mul_b1;
    logic [15:0] mul_p0, mul_p1, rsp_product0, rsp_product1;
    logic        rsp_valid0, rsp_valid1, rdy0, rdy1;
    logic [1:0]  rsp_id0, rsp_id1;

    exp_t        q0[$];
    exp_t        q1[$];
    int          gnt_log[$];
    int          gnt_cyc[$];
    logic [15:0] rsp_log[$];

    booth_mul_arbiter #(.NUM_REQ(4), .MUL_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_a(a0), .req_b(b0),
        .req_ready(rr0), .mul_a(mul_a0), .mul_b(mul_b0), .mul_product(mul_p0),
        .rsp_valid(rsp_valid0), .rsp_id(rsp_id0), .rsp_product(rsp_product0),
        .rsp_ready(rdy0)
    );

    booth_mul_arbiter #(.NUM_REQ(4), .MUL_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_a(a1), .req_b(b1),
        .req_ready(rr1), .mul_a(mul_a1), .mul_b(mul_b1), .mul_product(mul_p1),
        .rsp_valid(rsp_valid1), .rsp_id(rsp_id1), .rsp_product(rsp_product1),
        .rsp_ready(rdy1)
    );

    // Behavioural stand-in for the external combinational multiplier.
    assign mul_p0 = 16'($signed(mul_a0)) * 16'($signed(mul_b0));
    assign mul_p1 = 16'($signed(mul_a1)) * 16'($signed(mul_b1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Scoreboard for dut0: push on accept, pop on response handshake.
    always @(negedge clk) begin
        logic signed [7:0] ea, eb;
        exp_t e;
        acc0 = rr0;
        if (!rst_n) begin
            q0.delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (rr0[i]) begin
                    ea = a0[8*i +: 8];
                    eb = b0[8*i +: 8];
                    e.id = 2'(i);
                    e.p  = 16'(ea) * 16'(eb);
                    q0.push_back(e);
                    gnt_log.push_back(i);
                    gnt_cyc.push_back(cyc);
                end
            end
            if (rsp_valid0 && rdy0) begin
                checks++;
                rsp_log.push_back(rsp_product0);
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL sb0: unexpected response id=%0d prod=%0d", rsp_id0, $signed(rsp_product0));
                end else begin
                    e = q0.pop_front();
                    if (rsp_id0 !== e.id || rsp_product0 !== e.p) begin
                        errors++;
                        $display("FAIL sb0: got id=%0d prod=%0d, expected id=%0d prod=%0d",
                                 rsp_id0, $signed(rsp_product0), e.id, $signed(e.p));
                    end
                end
            end
        end
    end

    // Scoreboard for dut1; reset discards in-flight expectations.
    always @(negedge clk) begin
        logic signed [7:0] ea, eb;
        exp_t e;
        acc1 = rr1;
        if (!rst_n) begin
            q1.delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (rr1[i]) begin
                    ea = a1[8*i +: 8];
                    eb = b1[8*i +: 8];
                    e.id = 2'(i);
                    e.p  = 16'(ea) * 16'(eb);
                    q1.push_back(e);
                end
            end
            if (rsp_valid1 && rdy1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL sb1: unexpected response id=%0d prod=%0d", rsp_id1, $signed(rsp_product1));
                end else begin
                    e = q1.pop_front();
                    if (rsp_id1 !== e.id || rsp_product1 !== e.p) begin
                        errors++;
                        $display("FAIL sb1: got id=%0d prod=%0d, expected id=%0d prod=%0d",
                                 rsp_id1, $signed(rsp_product1), e.id, $signed(e.p));
                    end
                end
            end
        end
    end

    // Advance one clock; requesters drop req_valid once accepted.
    task automatic tick();
        @(posedge clk);
        #1;
        v0 = v0 & ~acc0;
        v1 = v1 & ~acc1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        v0 = '0;
        v1 = '0;
        tick();
        tick();
        rst_n = 1'b1;
        gnt_log.delete();
        gnt_cyc.delete();
        rsp_log.delete();
    endtask

    task automatic test_reset();
        v0 = 4'hF; v1 = 4'hF; a0 = 32'h11223344; b0 = 32'h55667788;
        a1 = '0; b1 = '0; rdy0 = 1'b1; rdy1 = 1'b1; acc0 = '0; acc1 = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rr0 !== 4'b0000 || rr1 !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b, expected 0000", rr0, rr1);
        end
        checks++;
        if (rsp_valid0 !== 1'b0 || rsp_id0 !== 2'd0 || rsp_product0 !== 16'd0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b id=%0d p=%h, expected 0/0/0000", rsp_valid0, rsp_id0, rsp_product0);
        end
        checks++;
        if (mul_a0 !== 8'd0 || mul_b0 !== 8'd0) begin
            errors++;
            $display("FAIL reset_mul: got a=%h b=%h, expected 00/00", mul_a0, mul_b0);
        end
        v0 = '0; v1 = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        v0 = 4'b0001; a0[7:0] = 8'd5; b0[7:0] = 8'd3; rdy0 = 1'b1;
        @(negedge clk);
        checks++;
        if (rr0 !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready: got %b, expected 0001", rr0);
        end
        tick();
        @(negedge clk);
        checks++;
        if (mul_a0 !== 8'd5 || mul_b0 !== 8'd3 || rsp_valid0 !== 1'b0 || rr0 !== 4'b0000) begin
            errors++;
            $display("FAIL single_mul: got a=%0d b=%0d v=%b rdy=%b, expected 5 3 0 0000", mul_a0, mul_b0, rsp_valid0, rr0);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rsp_valid0 !== 1'b1 || rsp_id0 !== 2'd0 || rsp_product0 !== 16'd15) begin
            errors++;
            $display("FAIL single_rsp: got v=%b id=%0d p=%0d, expected 1 0 15", rsp_valid0, rsp_id0, $signed(rsp_product0));
        end
        tick();
    endtask

    task automatic test_all4();
        logic [15:0] exp_p[4];
        exp_p = '{16'hFFE4, 16'hFFB8, 16'h0010, 16'h007F};
        apply_reset();
        a0 = {8'h7F, 8'hF8, 8'h0C, 8'hF9};
        b0 = {8'h01, 8'hFE, 8'hFA, 8'h04};
        v0 = 4'hF; rdy0 = 1'b1;
        for (int n = 0; n < 30 && rsp_log.size() < 4; n++) tick();
        checks++;
        if (rsp_log.size() != 4 || gnt_log.size() != 4) begin
            errors++;
            $display("FAIL all4_count: got %0d responses, expected 4", rsp_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (gnt_log[i] != i || rsp_log[i] !== exp_p[i]) begin
                    errors++;
                    $display("FAIL all4_order[%0d]: got id=%0d p=%0d, expected id=%0d p=%0d",
                             i, gnt_log[i], $signed(rsp_log[i]), i, $signed(exp_p[i]));
                end
                if (i > 0) begin
                    checks++;
                    if (gnt_cyc[i] - gnt_cyc[i-1] != 3) begin
                        errors++;
                        $display("FAIL all4_interval[%0d]: got %0d cycles, expected 3", i, gnt_cyc[i] - gnt_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_fairness();
        gnt_log.delete(); rsp_log.delete();
        v0 = 4'b0010;
        for (int n = 0; n < 10 && rsp_log.size() < 1; n++) tick();
        gnt_log.delete(); rsp_log.delete();
        v0 = 4'b1010;
        for (int n = 0; n < 20 && rsp_log.size() < 2; n++) tick();
        checks++;
        if (gnt_log.size() != 2 || gnt_log[0] != 3 || gnt_log[1] != 1) begin
            errors++;
            $display("FAIL fair_13: got %0d grants first=%0d, expected order 3,1", gnt_log.size(),
                     gnt_log.size() > 0 ? gnt_log[0] : -1);
        end
        gnt_log.delete(); rsp_log.delete();
        v0 = 4'b0101;
        for (int n = 0; n < 20 && rsp_log.size() < 2; n++) tick();
        checks++;
        if (gnt_log.size() != 2 || gnt_log[0] != 2 || gnt_log[1] != 0) begin
            errors++;
            $display("FAIL fair_ptr: got %0d grants first=%0d, expected order 2,0", gnt_log.size(),
                     gnt_log.size() > 0 ? gnt_log[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        apply_reset();
        a0[7:0] = 8'd3; b0[7:0] = 8'd4; a0[15:8] = 8'hFE; b0[15:8] = 8'd7;
        rdy0 = 1'b0;
        v0 = 4'b0011;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rsp_valid0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_wait: got no rsp_valid within 10 cycles, expected one");
        end
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid0 !== 1'b1 || rsp_id0 !== 2'd0 || rsp_product0 !== 16'd12 || rr0 !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d p=%0d rdy=%b, expected 1 0 12 0000",
                         c, rsp_valid0, rsp_id0, $signed(rsp_product0), rr0);
            end
            tick();
        end
        rdy0 = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if (rr0 !== 4'b0010) begin
            errors++;
            $display("FAIL bp_next_grant: got %b, expected 0010", rr0);
        end
        tick();
        for (int n = 0; n < 10 && rsp_log.size() < 2; n++) tick();
        checks++;
        if (rsp_log.size() != 2 || rsp_log[1] !== 16'hFFF2) begin
            errors++;
            $display("FAIL bp_req1: got %0d responses, expected 2 ending with -14", rsp_log.size());
        end
    endtask

    task automatic test_extremes();
        logic [7:0]  ta[3];
        logic [7:0]  tb[3];
        logic [15:0] te[3];
        ta = '{8'h80, 8'h80, 8'h00};
        tb = '{8'h80, 8'h7F, 8'hFF};
        te = '{16'h4000, 16'hC080, 16'h0000};
        rdy0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rsp_log.delete();
            a0[23:16] = ta[i]; b0[23:16] = tb[i];
            v0 = 4'b0100;
            for (int n = 0; n < 10 && rsp_log.size() < 1; n++) tick();
            checks++;
            if (rsp_log.size() != 1 || rsp_log[0] !== te[i]) begin
                errors++;
                $display("FAIL extreme[%0d]: got %0d responses p=%0d, expected p=%0d", i, rsp_log.size(),
                         rsp_log.size() > 0 ? $signed(rsp_log[0]) : 0, $signed(te[i]));
            end
        end
    endtask

    task automatic test_mulcycles3();
        rdy1 = 1'b1;
        a1[7:0] = 8'd9; b1[7:0] = 8'hF7;
        v1 = 4'b0001;
        @(negedge clk);
        checks++;
        if (rr1 !== 4'b0001) begin
            errors++;
            $display("FAIL mc3_ready: got %b, expected 0001", rr1);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (mul_a1 !== 8'd9 || mul_b1 !== 8'hF7 || rsp_valid1 !== 1'b0) begin
                errors++;
                $display("FAIL mc3_hold[%0d]: got a=%h b=%h v=%b, expected 09 f7 0", c, mul_a1, mul_b1, rsp_valid1);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (rsp_valid1 !== 1'b1 || rsp_id1 !== 2'd0 || rsp_product1 !== 16'hFFAF) begin
            errors++;
            $display("FAIL mc3_rsp: got v=%b id=%0d p=%0d, expected 1 0 -81", rsp_valid1, rsp_id1, $signed(rsp_product1));
        end
        tick();
        a1[7:0] = 8'd3; b1[7:0] = 8'd3;
        v1 = 4'b0001;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mul_a1 !== 8'd0 || mul_b1 !== 8'd0 || rsp_valid1 !== 1'b0 || rsp_id1 !== 2'd0 ||
            rsp_product1 !== 16'd0 || rr1 !== 4'b0000) begin
            errors++;
            $display("FAIL mc3_abort: got a=%h b=%h v=%b id=%0d p=%h rdy=%b, expected all zero",
                     mul_a1, mul_b1, rsp_valid1, rsp_id1, rsp_product1, rr1);
        end
        v1 = '0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid1 !== 1'b0 || rr1 !== 4'b0000) begin
                errors++;
                $display("FAIL mc3_post_reset[%0d]: got v=%b rdy=%b, expected 0 0000", c, rsp_valid1, rr1);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all4();
        test_fairness();
        test_backpressure();
        test_extremes();
        test_mulcycles3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
